// File: rtl/phase_acc_bank.sv
// Bank of NUM_VOICES phase accumulators with ring hard-sync, per-voice test hold,
// one-clock wrap pulse and saturating wrap-period measurement in phase ticks.
module phase_acc_bank #(
    parameter int NUM_VOICES = 3,
    parameter int FREQ_W     = 16,
    parameter int ACC_W      = 24,
    parameter int PER_W      = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        tick_i,
    input  logic [NUM_VOICES*FREQ_W-1:0] freq_i,
    input  logic [NUM_VOICES-1:0]        sync_en_i,
    input  logic [NUM_VOICES-1:0]        test_i,
    output logic [NUM_VOICES*ACC_W-1:0]  acc_o,
    output logic [NUM_VOICES-1:0]        msb_o,
    output logic [NUM_VOICES-1:0]        sync_src_o,
    output logic [NUM_VOICES-1:0]        wrap_o,
    output logic [NUM_VOICES*PER_W-1:0]  period_o
);

    logic [NUM_VOICES-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_VOICES-1:0][PER_W-1:0] period_q, period_d;
    logic [NUM_VOICES-1:0][PER_W-1:0] cnt_q, cnt_d;
    logic [NUM_VOICES-1:0]            sync_src_q, sync_src_d;
    logic [NUM_VOICES-1:0]            wrap_q, wrap_d;

    logic [NUM_VOICES-1:0][ACC_W:0]   sum;
    logic [NUM_VOICES-1:0][PER_W-1:0] cnt_inc;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        // Extra top bit of the sum is the accumulator carry-out.
        assign sum[g]     = {1'b0, acc_q[g]}
                          + {{(ACC_W + 1 - FREQ_W){1'b0}}, freq_i[g*FREQ_W +: FREQ_W]};
        assign cnt_inc[g] = (&cnt_q[g]) ? cnt_q[g] : cnt_q[g] + PER_W'(1);
        assign msb_o[g]   = acc_q[g][ACC_W-1];
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold/default value first, so no path infers a latch.
        acc_d      = acc_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        sync_src_d = sync_src_q;
        wrap_d     = '0;
        if (tick_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (test_i[i]) begin
                    acc_d[i]      = '0;
                    sync_src_d[i] = 1'b0;
                    cnt_d[i]      = '0;
                end else if (sync_en_i[i] && sync_src_q[(i == 0) ? NUM_VOICES - 1 : i - 1]) begin
                    // Source flag is last tick's register, so the ring has no combinational loop.
                    acc_d[i]      = '0;
                    sync_src_d[i] = 1'b0;
                    cnt_d[i]      = cnt_inc[i];
                end else begin
                    acc_d[i]      = sum[i][ACC_W-1:0];
                    sync_src_d[i] = ~acc_q[i][ACC_W-1] & sum[i][ACC_W-1];
                    if (sum[i][ACC_W]) begin
                        wrap_d[i]   = 1'b1;
                        period_d[i] = cnt_inc[i];
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i]    = cnt_inc[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            sync_src_q <= '0;
            wrap_q     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all voices update from one snapshot.
            acc_q      <= acc_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            sync_src_q <= sync_src_d;
            wrap_q     <= wrap_d;
        end
    end

    assign acc_o      = acc_q;
    assign period_o   = period_q;
    assign sync_src_o = sync_src_q;
    assign wrap_o     = wrap_q;

endmodule
